// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the display colour adapter:
//   - disp_mode_t : colour mode encoding (pass / greyscale / invert / reserved)
//   - LUMA_*      : integer luma weights, summing to 2**LUMA_SHIFT
//   - BAYER       : 4x4 ordered-dither threshold matrix (values 0..15)
//   - bayer_thr() : threshold lookup by row/column
// -----------------------------------------------------------------------------
package disp_pkg;

    // The reserved code 3 behaves exactly like MODE_PASS.
    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_GREY = 2'd1,
        MODE_INV  = 2'd2,
        MODE_RSVD = 2'd3
    } disp_mode_t;

    // luma = (5r + 9g + 2b) >> 4; the weights sum to 16, so the sum fits in
    // channel width + LUMA_SHIFT bits and the shifted result never overflows.
    localparam int LUMA_R     = 5;
    localparam int LUMA_G     = 9;
    localparam int LUMA_B     = 2;
    localparam int LUMA_SHIFT = 4;

    // Classic 4x4 Bayer matrix, indexed [row][col].
    localparam logic [3:0] BAYER [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    function automatic logic [3:0] bayer_thr(input logic [1:0] row,
                                             input logic [1:0] col);
        return BAYER[row][col];
    endfunction

endpackage

// File: rtl/disp_chan_conv.sv
// -----------------------------------------------------------------------------
// disp_chan_conv
// Combinational width conversion of one colour channel.
//   BPC_OUT >  BPC_IN : input bits repeated MSB-first until the output is full
//   BPC_OUT == BPC_IN : pass through
//   BPC_OUT <  BPC_IN : truncation to the top bits, or, with DISP_DITHER_EN
//                       defined, ordered dither with saturation
// Ports:
//   chan  in  BPC_IN   channel value
//   thr   in  4        raw Bayer threshold (0..15), only used when dithering
//   conv  out BPC_OUT  converted channel value
// Optional feature macro: DISP_DITHER_EN
// -----------------------------------------------------------------------------
module disp_chan_conv #(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8
) (
    input  logic [BPC_IN-1:0]  chan,
    input  logic [3:0]         thr,
    output logic [BPC_OUT-1:0] conv
);

    if (BPC_OUT > BPC_IN) begin : g_expand
        // Output bit i (counted from the MSB) takes input bit (i mod BPC_IN),
        // also counted from the MSB: 5->8 gives {c, c[4:2]}.
        for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
            assign conv[BPC_OUT-1-i] = chan[BPC_IN-1-(i % BPC_IN)];
        end
        logic unused_thr;
        assign unused_thr = ^thr;

    end else if (BPC_OUT == BPC_IN) begin : g_equal
        assign conv = chan;
        logic unused_thr;
        assign unused_thr = ^thr;

    end else begin : g_reduce
        localparam int D = BPC_IN - BPC_OUT;

`ifdef DISP_DITHER_EN
        // Threshold rescaled from the 0..15 range to the D discarded bits so
        // it never exceeds 2**D - 1.
        logic [D-1:0]      t_s;
        logic [BPC_IN:0]   sum;
        logic [BPC_OUT:0]  q;

        if (D <= 4) begin : g_tdown
            assign t_s = D'(thr >> (4 - D));
        end else begin : g_tup
            assign t_s = {thr, {(D-4){1'b0}}};
        end

        // One extra bit holds the carry; a set carry bit means the rounded
        // value reached 2**BPC_OUT and must saturate to all ones.
        assign sum  = {1'b0, chan} + (BPC_IN+1)'(t_s);
        assign q    = (BPC_OUT+1)'(sum >> D);
        assign conv = q[BPC_OUT] ? {BPC_OUT{1'b1}} : q[BPC_OUT-1:0];
`else
        assign conv = chan[BPC_IN-1:D];
        logic unused_bits;
        assign unused_bits = ^{thr, chan[D-1:0]};
`endif
    end

endmodule

// File: rtl/disp_colr_adapt.sv
// -----------------------------------------------------------------------------
// disp_colr_adapt
// Display colour adapter: per-frame colour mode (pass / greyscale / invert)
// followed by per-channel width conversion from BPC_IN to BPC_OUT bits.
// Position, enable and frame pulse travel through the same two register
// stages as the colour, so every output lags its input by exactly 2 cycles.
//
// Parameters:
//   BPC_IN   input bits per channel  (1..12)
//   BPC_OUT  output bits per channel (1..12), BPC_IN - BPC_OUT <= 8
//   CORDW    signed coordinate width
// Ports:
//   clk_pix, rst_pix                pixel clock, synchronous active-high reset
//   mode                            requested colour mode, latched at in_frame
//   in_x, in_y, in_de, in_frame     input timing
//   in_r, in_g, in_b                input colour (BPC_IN)
//   out_x, out_y, out_de, out_frame timing delayed by 2 cycles
//   out_r, out_g, out_b             converted colour (BPC_OUT), 0 in blanking
// Optional feature macro: DISP_DITHER_EN (ordered dither on width reduction)
// -----------------------------------------------------------------------------
module disp_colr_adapt
    import disp_pkg::*;
#(
    parameter int BPC_IN  = 5,
    parameter int BPC_OUT = 8,
    parameter int CORDW   = 16
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic [1:0]              mode,
    input  logic signed [CORDW-1:0] in_x,
    input  logic signed [CORDW-1:0] in_y,
    input  logic                    in_de,
    input  logic                    in_frame,
    input  logic [BPC_IN-1:0]       in_r,
    input  logic [BPC_IN-1:0]       in_g,
    input  logic [BPC_IN-1:0]       in_b,
    output logic signed [CORDW-1:0] out_x,
    output logic signed [CORDW-1:0] out_y,
    output logic                    out_de,
    output logic                    out_frame,
    output logic [BPC_OUT-1:0]      out_r,
    output logic [BPC_OUT-1:0]      out_g,
    output logic [BPC_OUT-1:0]      out_b
);

    localparam int LW = BPC_IN + LUMA_SHIFT;

    // Frame-level state
    disp_mode_t mode_q;
    logic [1:0] fc;

    // Stage 1: mode-transformed pixel at input depth
    logic signed [CORDW-1:0] s1_x, s1_y;
    logic                    s1_de, s1_frame;
    logic [BPC_IN-1:0]       s1_r, s1_g, s1_b;

    // Stage 1 combinational transform
    disp_mode_t        eff_mode;
    logic [LW-1:0]     luma_sum;
    logic [BPC_IN-1:0] luma;
    logic [BPC_IN-1:0] xf_r, xf_g, xf_b;

    // Stage 2 combinational conversion
    logic [3:0]         thr;
    logic [BPC_OUT-1:0] conv_r, conv_g, conv_b;

    // -------------------------------------------------------------------------
    // Stage 1 transform
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a value on every path through this block
        // (defaults first, default arm in the case) so no latch is inferred.
        xf_r = in_r;
        xf_g = in_g;
        xf_b = in_b;

        // The frame-start pixel already uses the mode requested with it.
        eff_mode = in_frame ? disp_mode_t'(mode) : mode_q;

        luma_sum = LW'(LUMA_R) * LW'(in_r)
                 + LW'(LUMA_G) * LW'(in_g)
                 + LW'(LUMA_B) * LW'(in_b);
        luma     = BPC_IN'(luma_sum >> LUMA_SHIFT);

        case (eff_mode)
            MODE_GREY: begin
                xf_r = luma;
                xf_g = luma;
                xf_b = luma;
            end
            MODE_INV: begin
                xf_r = ~in_r;
                xf_g = ~in_g;
                xf_b = ~in_b;
            end
            default: ;  // MODE_PASS and the reserved code leave colour as is
        endcase
    end

    // -------------------------------------------------------------------------
    // Frame state and stage 1 registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pix) begin
        // NOTE: the reset is synchronous and clears every register of the
        // pipeline, so the first two post-reset outputs are all zero.
        if (rst_pix) begin
            mode_q   <= MODE_PASS;
            fc       <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_de    <= 1'b0;
            s1_frame <= 1'b0;
            s1_r     <= '0;
            s1_g     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_frame) begin
                mode_q <= disp_mode_t'(mode);
                fc     <= fc + 2'd1;
            end
            s1_x     <= in_x;
            s1_y     <= in_y;
            s1_de    <= in_de;
            s1_frame <= in_frame;
            s1_r     <= xf_r;
            s1_g     <= xf_g;
            s1_b     <= xf_b;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2 width conversion
    // -------------------------------------------------------------------------
    // fc has already advanced when the frame-start pixel sits in stage 1, so
    // the whole frame, including its first pixel, shares one dither phase.
    // XOR-ing the position with the frame count shifts the pattern each frame.
    assign thr = bayer_thr(s1_y[1:0] ^ {2{fc[1]}}, s1_x[1:0] ^ {2{fc[0]}});

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv_r (
        .chan (s1_r),
        .thr  (thr),
        .conv (conv_r)
    );

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv_g (
        .chan (s1_g),
        .thr  (thr),
        .conv (conv_g)
    );

    disp_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT)) u_conv_b (
        .chan (s1_b),
        .thr  (thr),
        .conv (conv_b)
    );

    // -------------------------------------------------------------------------
    // Stage 2 registers (outputs)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            out_x     <= '0;
            out_y     <= '0;
            out_de    <= 1'b0;
            out_frame <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
        end else begin
            out_x     <= s1_x;
            out_y     <= s1_y;
            out_de    <= s1_de;
            out_frame <= s1_frame;
            // Colour is blanked while enable is low; timing still propagates.
            out_r     <= s1_de ? conv_r : '0;
            out_g     <= s1_de ? conv_g : '0;
            out_b     <= s1_de ? conv_b : '0;
        end
    end

endmodule

// File: doc/disp_colr_adapt.md
# disp_colr_adapt

Parametrised display colour adapter sitting between the display pipeline (x/y/de/frame plus RGB at system depth) and a board or simulator video sink. Converts any input bits-per-channel to any board bits-per-channel (bit-replication expansion, truncation or ordered-dither reduction) and applies a per-frame colour mode (pass, greyscale, invert). All timing signals are delayed through the same two-stage pipeline so colour and position stay aligned.

## Interface
- BPC_IN, 5, input bits per colour channel (1–12)
- BPC_OUT, 8, output bits per colour channel (1–12); BPC_IN-BPC_OUT ≤ 8
- CORDW, 16, signed coordinate width
- clk_pix  in  1  pixel clock; one clock, all logic on rising edge
- rst_pix  in  1  reset, synchronous, active-high
- mode  in  2  colour mode request: 0 pass, 1 greyscale, 2 invert, 3 treated as pass
- in_x, in_y  in  CORDW each  signed display position
- in_de  in  1  data enable (low in blanking)
- in_frame  in  1  one-cycle pulse at frame start
- in_r, in_g, in_b  in  BPC_IN each  input colour
- out_x, out_y  out  CORDW each  delayed position
- out_de, out_frame  out  1 each  delayed enable / frame pulse
- out_r, out_g, out_b  out  BPC_OUT each  converted colour

## Operation
- Active mode register (mode_q) loads `mode` only in the cycle in_frame=1; mid-frame changes are ignored until next frame pulse. The loaded mode applies to the pixel carrying in_frame.
- 2-bit frame counter fc increments (wraps 3→0) on each in_frame.
- Stage 1 (mode transform, BPC_IN wide): pass: unchanged. Greyscale: luma=(5r+9g+2b)>>4 computed at BPC_IN+4 bits (coefficients sum 16, no overflow), luma driven to all three channels. Invert: bitwise NOT each channel.
- Stage 2 (width conversion per channel):
  - BPC_OUT>BPC_IN: repeat input bits MSB-first until BPC_OUT filled (5→8: {c,c[4:2]}).
  - Equal: pass through.
  - BPC_OUT<BPC_IN, d=BPC_IN-BPC_OUT: truncate to top BPC_OUT bits, or dither (see Configuration).
- Blanking: when delayed de=0, out_r/g/b forced to 0; x/y/frame still propagate.

## Timing
- Latency exactly 2 cycles for every output; in at cycle N → out at N+2, no stalls, no backpressure.
- Reset: all outputs 0 (out_x/out_y 0, out_de 0, out_frame 0, colour 0), both pipeline stages cleared, mode_q=0, fc=0. Reset mid-frame takes effect next edge; the first two post-reset cycles output zeros.
- Simultaneous in_frame and mode change: new mode captured and applied to that pixel.
- fc and mode_q update on the same edge as in_frame enters stage 1; dither for the frame-start pixel uses the already-incremented fc.

## Configuration
- DISP_DITHER_EN defined: on reduction, 4×4 Bayer ordered dither. Index row = in_y[1:0]^{fc[1],fc[1]}, col = in_x[1:0]^{fc[0],fc[0]}; threshold t (0–15) scaled to d bits: t>>(4-d) if d≤4, else t<<(d-4). Output = min((c+t)>>d, 2^BPC_OUT-1) (saturate). x/y carried into stage 2 for this.
- Not defined: reduction is plain truncation; fc still counts (no dither use). Expansion/equal unaffected either way.

## Structure
- Package disp_pkg: mode constants (MODE_PASS, MODE_GREY, MODE_INV), Bayer 4×4 table, luma coefficients.
- Sub-module disp_chan_conv: single-channel width conversion + dither, instantiated three times.

## Test plan
- BPC 5→8, mode 0, de=1, r/g/b=5'h1F/5'h10/5'h01 → two cycles later 8'hFF/8'h84/8'h08, x/y/de aligned.
- Same colour with de=0 → out colour 0, out_x/out_y match input delayed 2.
- mode=1 raised mid-frame, r=31 g=0 b=0 → pass until next in_frame; from that pixel all channels 8'h4A.
- BPC 8→5, no macro: 8'hFF→5'h1F, 8'h87→5'h10. With DISP_DITHER_EN, fc=0, (x,y)=(1,0): 8'h87→5'h11; 8'hFF→5'h1F (saturated).
- Four in_frame pulses → fc back to 0; dither output at fixed pixel repeats with period 4 frames.
- rst_pix pulsed mid-frame with mode_q=2 → next edge all outputs 0, mode_q=0; first frame after reset in pass mode.
